uart_tx_port: RTL

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/microcpu_io_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 92 +++++++++
 rtl/uart_tx_port.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/microcpu_io_pkg.sv
// ---------------------------------------------------------------------------
// microcpu_io_pkg
// Shared definitions for memory-mapped peripherals on the micro-CPU bus.
// Holds the UART register index constants, the STATUS bit positions and a
// helper that assembles the STATUS byte from its individual flags.
// ---------------------------------------------------------------------------
package microcpu_io_pkg;

    // Register indices decoded from cpu address[1:0]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // Bit positions inside the STATUS register
    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;

    // Assemble the STATUS byte; the upper nibble always reads as zero
    function automatic logic [7:0] packStatus(input logic full,
                                              input logic empty,
                                              input logic busy,
                                              input logic overflow);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_FULL]     = full;
        s[STAT_EMPTY]    = empty;
        s[STAT_BUSY]     = busy;
        s[STAT_OVERFLOW] = overflow;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in first-out buffer with registered pointers.
//
// Parameters
//   WIDTH  data width in bits
//   DEPTH  number of entries, power of two
//
// Ports
//   clk    system clock, all updates on the rising edge
//   rst    synchronous active-high reset, empties the buffer
//   push   write din into the tail (ignored while full)
//   pop    drop the head entry (ignored while empty)
//   din    write data
//   dout   head entry, valid while empty is low
//   full   no free entries remain
//   empty  no entries stored
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Fullness is judged on the registered count, so a push into a full
    // buffer is refused even when the same cycle also pops an entry.
    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem_q[rdPtr_q];

    // Pointers wrap naturally because DEPTH is a power of two; a
    // simultaneous push and pop leaves the count where it was.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// ---------------------------------------------------------------------------
// uart_tx_port
// Memory-mapped UART transmitter for the micro-CPU bus. Bytes written to
// DATA are queued in a small FIFO and shifted out 8N1, LSB first, with a
// programmable bit time of BAUD+1 clock cycles.
//
// Parameters
//   DEPTH    TX FIFO entries (power of two, 2..16)
//   DIV_RST  value loaded into BAUD by reset
//
// Ports
//   clk    system clock shared with cpu and sram
//   rst    synchronous active-high reset
//   sel    decoded chip select, active high
//   addr   register index (0 DATA, 1 STATUS, 2 BAUD, 3 reserved)
//   read   bus direction, 1 = read, 0 = write
//   wdata  write data from the cpu
//   rdata  read data back to the cpu, zero when not selected for a read
//   txd    serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx_port
    import microcpu_io_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] DIV_RST = 8'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [1:0] addr,
    input  logic       read,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       txd
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } txState_e;

    txState_e   state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [7:0] bitCnt_q, bitCnt_d;
    logic [2:0] bitIdx_q, bitIdx_d;
    logic [7:0] shifter_q, shifter_d;
    logic       overflow_q, overflow_d;
    logic       txd_q, txd_d;

    logic       busWrite;
    logic       statusRead;
    logic       pushReq;
    logic       fifoPop;
    logic [7:0] fifoDout;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       bitDone;
    logic [7:0] statusByte;

    assign busWrite   = sel && !read;
    assign statusRead = sel && read && (addr == REG_STATUS);
    assign pushReq    = busWrite && (addr == REG_DATA);
    assign statusByte = packStatus(fifoFull, fifoEmpty,
                                   (state_q != ST_IDLE), overflow_q);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushReq),
        .pop   (fifoPop),
        .din   (wdata),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Read mux; DATA is write-only and the reserved slot reads as zero
    always_comb begin
        rdata = 8'h00;
        if (sel && read) begin
            case (addr)
                REG_STATUS: rdata = statusByte;
                REG_BAUD:   rdata = baud_q;
                default:    rdata = 8'h00;
            endcase
        end
    end

    // BAUD register and sticky overflow flag. A push that is refused in
    // the same cycle as a STATUS read keeps the flag set.
    always_comb begin
        baud_d     = baud_q;
        overflow_d = overflow_q;
        if (busWrite && (addr == REG_BAUD)) begin
            baud_d = wdata;
        end
        if (pushReq && fifoFull) begin
            overflow_d = 1'b1;
        end else if (statusRead) begin
            overflow_d = 1'b0;
        end
    end

    // Transmit sequencer. The bit counter is reloaded from BAUD only when
    // a new bit begins, so a BAUD change never shortens the bit in flight.
    // Leaving STOP with data waiting goes straight to START so consecutive
    // frames have no idle gap.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        bitIdx_d  = bitIdx_q;
        shifter_d = shifter_q;
        fifoPop   = 1'b0;
        bitDone   = (bitCnt_q == 8'd0);
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shifter_d = fifoDout;
                    bitCnt_d  = baud_q;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bitDone) begin
                    bitCnt_d = baud_q;
                    bitIdx_d = 3'd0;
                    state_d  = ST_DATA;
                end else begin
                    bitCnt_d = bitCnt_q - 8'd1;
                end
            end
            ST_DATA: begin
                if (bitDone) begin
                    bitCnt_d = baud_q;
                    if (bitIdx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bitIdx_d  = bitIdx_q + 3'd1;
                        shifter_d = {1'b0, shifter_q[7:1]};
                    end
                end else begin
                    bitCnt_d = bitCnt_q - 8'd1;
                end
            end
            ST_STOP: begin
                if (bitDone) begin
                    if (!fifoEmpty) begin
                        fifoPop   = 1'b1;
                        shifter_d = fifoDout;
                        bitCnt_d  = baud_q;
                        state_d   = ST_START;
                    end else begin
                        bitCnt_d = 8'd0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    bitCnt_d = bitCnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bitCnt_d = 8'd0;
            end
        endcase
    end

    // The line level is registered from the next state so txd changes
    // exactly on the edge that enters each bit and never glitches.
    always_comb begin
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shifter_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and beats a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= DIV_RST;
            bitCnt_q   <= 8'd0;
            bitIdx_q   <= 3'd0;
            shifter_q  <= 8'h00;
            overflow_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bitCnt_q   <= bitCnt_d;
            bitIdx_q   <= bitIdx_d;
            shifter_q  <= shifter_d;
            overflow_q <= overflow_d;
            txd_q      <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule
